mem_stage_register_p: RTL and testbench

- Parametrised execute-to-memory pipeline register for the Y86-64 pipeline; successor to the fixed E/M latch.
- Captures execute-stage results each cycle and supports stall (hold), bubble (full NOP injection) and a valid flag.
- Freezes permanently once an exception status has been latched, until reset.
- Sits between the execute stage and the data-memory stage; the pipeline control unit drives M_stall and M_bubble.

---
 rtl/mem_stage_register_p.sv | 147 ++++++++++++++
 tb/tb_mem_stage_register_p.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_register_p.sv
// Execute-to-memory pipeline register with stall, bubble, valid flag and exception freeze.
// Optional performance counters are enabled by defining MEM_STAGE_PERF_CNT_EN.
module mem_stage_register_p #(
    parameter int                 DATA_W    = 64,
    parameter int                 REG_W     = 4,
    parameter int                 ICODE_W   = 4,
    parameter logic [ICODE_W-1:0] NOP_ICODE = ICODE_W'(1),
    parameter logic [REG_W-1:0]   RNONE     = REG_W'(15),
    parameter logic [1:0]         STAT_AOK  = 2'd0
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               M_stall,
    input  logic               M_bubble,
    input  logic [1:0]         e_status,
    input  logic [ICODE_W-1:0] e_icode,
    input  logic               e_cnd,
    input  logic [REG_W-1:0]   e_dste,
    input  logic [REG_W-1:0]   e_dstm,
    input  logic [DATA_W-1:0]  e_vala,
    input  logic [DATA_W-1:0]  e_vale,
    output logic [1:0]         M_status,
    output logic [ICODE_W-1:0] M_icode,
    output logic               M_cnd,
    output logic [REG_W-1:0]   M_dste,
    output logic [REG_W-1:0]   M_dstm,
    output logic [DATA_W-1:0]  M_vala,
    output logic [DATA_W-1:0]  M_vale,
    output logic               M_valid,
    output logic               M_halted
`ifdef MEM_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]        perf_loads,
    output logic [31:0]        perf_stalls,
    output logic [31:0]        perf_bubbles
`endif
);

    typedef enum logic {RUN, HALT} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 status_p1, status_d;
    logic [ICODE_W-1:0]         icode_p1, icode_d;
    logic                       cnd_p1, cnd_d;
    logic [REG_W-1:0]           dste_p1, dste_d;
    logic [REG_W-1:0]           dstm_p1, dstm_d;
    logic signed [DATA_W-1:0]   vala_p1, vala_d;
    logic signed [DATA_W-1:0]   vale_p1, vale_d;
    logic                       vld_p1, vld_d;

    always_comb begin
        state_d  = state_q;
        status_d = status_p1;
        icode_d  = icode_p1;
        cnd_d    = cnd_p1;
        dste_d   = dste_p1;
        dstm_d   = dstm_p1;
        vala_d   = vala_p1;
        vale_d   = vale_p1;
        vld_d    = vld_p1;
        case (state_q)
            RUN: begin
                if (M_bubble) begin
                    // Bubble forces AOK, so it can never enter HALT.
                    status_d = STAT_AOK;
                    icode_d  = NOP_ICODE;
                    cnd_d    = 1'b0;
                    dste_d   = RNONE;
                    dstm_d   = RNONE;
                    vala_d   = '0;
                    vale_d   = '0;
                    vld_d    = 1'b0;
                end else if (!M_stall) begin
                    status_d = e_status;
                    icode_d  = e_icode;
                    cnd_d    = e_cnd;
                    dste_d   = e_dste;
                    dstm_d   = e_dstm;
                    vala_d   = $signed(e_vala);
                    vale_d   = $signed(e_vale);
                    vld_d    = 1'b1;
                    if (e_status != STAT_AOK) state_d = HALT;
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase
    end

    // Execute -> memory stage boundary
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= RUN;
            status_p1 <= STAT_AOK;
            icode_p1  <= NOP_ICODE;
            cnd_p1    <= 1'b0;
            dste_p1   <= RNONE;
            dstm_p1   <= RNONE;
            vala_p1   <= '0;
            vale_p1   <= '0;
            vld_p1    <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_p1 <= status_d;
            icode_p1  <= icode_d;
            cnd_p1    <= cnd_d;
            dste_p1   <= dste_d;
            dstm_p1   <= dstm_d;
            vala_p1   <= vala_d;
            vale_p1   <= vale_d;
            vld_p1    <= vld_d;
        end
    end

    assign M_status = status_p1;
    assign M_icode  = icode_p1;
    assign M_cnd    = cnd_p1;
    assign M_dste   = dste_p1;
    assign M_dstm   = dstm_p1;
    assign M_vala   = $unsigned(vala_p1);
    assign M_vale   = $unsigned(vale_p1);
    assign M_valid  = vld_p1;
    assign M_halted = (state_q == HALT);

`ifdef MEM_STAGE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic in_run;
    assign in_run = (state_q == RUN);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            perf_loads   <= '0;
            perf_stalls  <= '0;
            perf_bubbles <= '0;
        end else if (in_run) begin
            if (M_bubble)     perf_bubbles <= sat_inc(perf_bubbles);
            else if (M_stall) perf_stalls  <= sat_inc(perf_stalls);
            else              perf_loads   <= sat_inc(perf_loads);
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_register_p.sv
// Self-checking bench for mem_stage_register_p: directed steps followed by randomized
// cycles compared against a rule-level reference model.
module tb_mem_stage_register_p;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        M_stall, M_bubble;
    logic [1:0]  e_status;
    logic [3:0]  e_icode;
    logic        e_cnd;
    logic [3:0]  e_dste, e_dstm;
    logic [63:0] e_vala, e_vale;
    logic [1:0]  M_status;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [3:0]  M_dste, M_dstm;
    logic [63:0] M_vala, M_vale;
    logic        M_valid, M_halted;
`ifdef MEM_STAGE_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stalls, perf_bubbles;
    int unsigned x_loads, x_stalls, x_bubbles;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  status;
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  dste, dstm;
        logic [63:0] vala, vale;
        logic        valid, halted;
    } exp_t;

    exp_t m;

    mem_stage_register_p dut (
        .clock(clock), .reset_n(reset_n), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_status(e_status), .e_icode(e_icode), .e_cnd(e_cnd),
        .e_dste(e_dste), .e_dstm(e_dstm), .e_vala(e_vala), .e_vale(e_vale),
        .M_status(M_status), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_dste(M_dste), .M_dstm(M_dstm), .M_vala(M_vala), .M_vale(M_vale),
        .M_valid(M_valid), .M_halted(M_halted)
`ifdef MEM_STAGE_PERF_CNT_EN
        , .perf_loads(perf_loads), .perf_stalls(perf_stalls), .perf_bubbles(perf_bubbles)
`endif
    );

    always #5 clock = ~clock;

    function automatic exp_t nop_vals();
        exp_t r;
        r.status = 2'd0; r.icode = 4'd1; r.cnd = 1'b0;
        r.dste = 4'd15; r.dstm = 4'd15; r.vala = 64'd0; r.vale = 64'd0;
        r.valid = 1'b0; r.halted = 1'b0;
        return r;
    endfunction

    // Reference: what the register should hold after the coming edge.
    task automatic model_edge();
        if (!reset_n) begin
            m = nop_vals();
`ifdef MEM_STAGE_PERF_CNT_EN
            x_loads = 0; x_stalls = 0; x_bubbles = 0;
`endif
        end else if (!m.halted) begin
            if (M_bubble) begin
                m = nop_vals();
`ifdef MEM_STAGE_PERF_CNT_EN
                x_bubbles++;
`endif
            end else if (M_stall) begin
`ifdef MEM_STAGE_PERF_CNT_EN
                x_stalls++;
`endif
            end else begin
                m.status = e_status; m.icode = e_icode; m.cnd = e_cnd;
                m.dste = e_dste; m.dstm = e_dstm; m.vala = e_vala; m.vale = e_vale;
                m.valid = 1'b1;
                m.halted = (e_status != 2'd0);
`ifdef MEM_STAGE_PERF_CNT_EN
                x_loads++;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".status"}, 64'(M_status), 64'(m.status));
        chk({tag, ".icode"},  64'(M_icode),  64'(m.icode));
        chk({tag, ".cnd"},    64'(M_cnd),    64'(m.cnd));
        chk({tag, ".dste"},   64'(M_dste),   64'(m.dste));
        chk({tag, ".dstm"},   64'(M_dstm),   64'(m.dstm));
        chk({tag, ".vala"},   M_vala,        m.vala);
        chk({tag, ".vale"},   M_vale,        m.vale);
        chk({tag, ".valid"},  64'(M_valid),  64'(m.valid));
        chk({tag, ".halted"}, 64'(M_halted), 64'(m.halted));
`ifdef MEM_STAGE_PERF_CNT_EN
        chk({tag, ".perf_loads"},   64'(perf_loads),   64'(x_loads));
        chk({tag, ".perf_stalls"},  64'(perf_stalls),  64'(x_stalls));
        chk({tag, ".perf_bubbles"}, 64'(perf_bubbles), 64'(x_bubbles));
`endif
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic set_e(input logic [1:0] st, input logic [3:0] ic, input logic [63:0] ve);
        e_status = st; e_icode = ic; e_vale = ve;
        e_cnd = 1'($urandom); e_dste = 4'($urandom); e_dstm = 4'($urandom);
        e_vala = {$urandom, $urandom};
    endtask

    task automatic ctl(input logic rn, input logic st, input logic bb);
        reset_n = rn; M_stall = st; M_bubble = bb;
    endtask

    initial begin
        m = nop_vals();
`ifdef MEM_STAGE_PERF_CNT_EN
        x_loads = 0; x_stalls = 0; x_bubbles = 0;
`endif
        ctl(1'b0, 1'b0, 1'b0);
        set_e(2'd0, 4'd0, 64'd0);

        // 1: reset values, then a single load
        step("t1_reset");
        step("t1_reset2");
        chk("t1_reset_dste", 64'(M_dste), 64'd15);
        chk("t1_reset_icode", 64'(M_icode), 64'd1);
        ctl(1'b1, 1'b0, 1'b0);
        set_e(2'd0, 4'd6, 64'h10); e_dste = 4'd3;
        step("t1_load");
        chk("t1_icode", 64'(M_icode), 64'd6);
        chk("t1_vale", M_vale, 64'h10);
        chk("t1_dste", 64'(M_dste), 64'd3);
        chk("t1_valid", 64'(M_valid), 64'd1);

        // 2: stall holds while e_* changes
        set_e(2'd0, 4'd3, 64'h55);
        step("t2_load");
        ctl(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_e(2'd0, 4'($urandom_range(0, 11)), {$urandom, $urandom});
            step("t2_stall");
            chk("t2_hold_icode", 64'(M_icode), 64'd3);
            chk("t2_hold_vale", M_vale, 64'h55);
        end
        ctl(1'b1, 1'b0, 1'b0);
        set_e(2'd0, 4'd4, 64'h66);
        step("t2_release");
        chk("t2_new_icode", 64'(M_icode), 64'd4);
        chk("t2_new_vale", M_vale, 64'h66);

        // 3: bubble beats stall
        ctl(1'b1, 1'b1, 1'b1);
        set_e(2'd0, 4'd5, 64'h77);
        step("t3_bubble");
        chk("t3_icode", 64'(M_icode), 64'd1);
        chk("t3_dste", 64'(M_dste), 64'd15);
        chk("t3_dstm", 64'(M_dstm), 64'd15);
        chk("t3_vala", M_vala, 64'd0);
        chk("t3_vale", M_vale, 64'd0);
        chk("t3_valid", 64'(M_valid), 64'd0);

        // 4: faulting load freezes until reset
        ctl(1'b1, 1'b0, 1'b0);
        set_e(2'd3, 4'hF, 64'h1234);
        step("t4_fault");
        chk("t4_status", 64'(M_status), 64'd3);
        chk("t4_halted", 64'(M_halted), 64'd1);
        chk("t4_icode", 64'(M_icode), 64'hF);
        for (int i = 0; i < 5; i++) begin
            ctl(1'b1, 1'($urandom), 1'b1);
            set_e(2'($urandom), 4'($urandom), {$urandom, $urandom});
            step("t4_frozen");
            chk("t4_frozen_icode", 64'(M_icode), 64'hF);
            chk("t4_frozen_vale", M_vale, 64'h1234);
        end
        ctl(1'b0, 1'b1, 1'b1);
        step("t4_reset");
        chk("t4_reset_halted", 64'(M_halted), 64'd0);
        chk("t4_reset_icode", 64'(M_icode), 64'd1);

        // 5: bubble with bad status stays in RUN
        ctl(1'b1, 1'b0, 1'b1);
        set_e(2'd2, 4'd7, 64'h99);
        step("t5_bubble");
        chk("t5_status", 64'(M_status), 64'd0);
        chk("t5_halted", 64'(M_halted), 64'd0);

`ifdef MEM_STAGE_PERF_CNT_EN
        // 6: counter totals across loads, stalls, bubble and HALT
        ctl(1'b0, 1'b0, 1'b0);
        step("t6_reset");
        ctl(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            set_e(2'd0, 4'($urandom_range(0, 11)), {$urandom, $urandom});
            step("t6_load");
        end
        ctl(1'b1, 1'b1, 1'b0); step("t6_stall"); step("t6_stall");
        ctl(1'b1, 1'b0, 1'b1); step("t6_bubble");
        ctl(1'b1, 1'b0, 1'b0);
        set_e(2'd1, 4'd0, 64'd0);
        step("t6_fault");
        for (int i = 0; i < 3; i++) begin
            ctl(1'b1, 1'($urandom), 1'($urandom));
            step("t6_halted");
        end
        chk("t6_loads", 64'(perf_loads), 64'd5);
        chk("t6_stalls", 64'(perf_stalls), 64'd2);
        chk("t6_bubbles", 64'(perf_bubbles), 64'd1);
`endif

        // Randomized cycles against the reference model
        for (int i = 0; i < 400; i++) begin
            ctl(($urandom_range(0, 24) != 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0));
            set_e(($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  4'($urandom), {$urandom, $urandom});
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
